pyramid_output_arbiter: RTL and testbench
=========================================

Name: pyramid_output_arbiter

Overview:
- Merges the LEVELS independent valid/ready pixel streams from the gaussian pyramid into one tagged stream for the downstream HOG gradient/cell stage.
- Grants one level at a time, round-robin, in bursts of up to BURST_LEN beats.
- Each forwarded pixel carries its level index, so a single HOG engine can be time-shared across all scales.
- Sits between the pyramid outputs (pyramid_pixels / out_valid / out_ready) and the HOG front end.

Parameters:
- DATA_WIDTH, 8, pixel width in bits.
- LEVELS, 15, number of pyramid levels, i.e. requesters; legal range 2..32.
- BURST_LEN, 8, maximum beats accepted per grant; must be ≥ 1.
- LEVEL_W, $clog2(LEVELS), width of the level tag (derived; do not override).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  arbitration enable. When low, no new grant is issued; a burst already in progress completes.
- in_valid  in  LEVELS  per-level pixel valid.
- in_pixels  in  DATA_WIDTH*LEVELS  concatenated level pixels; level i is at [i*DATA_WIDTH +: DATA_WIDTH].
- in_ready  out  LEVELS  per-level ready; one-hot or zero.
- out_valid  out  1  merged output valid.
- out_ready  in  1  downstream ready.
- out_pixel  out  DATA_WIDTH  merged pixel.
- out_level  out  LEVEL_W  source level of out_pixel.
- busy  out  1  high while in state GRANT or while out_valid is high.

Behaviour:
- Reset (asynchronous): state=IDLE, rr_ptr=0, grant=0, burst_cnt=0, out_valid=0, out_pixel=0, out_level=0, in_ready=0, busy=0.
- State IDLE:
  - If en && |in_valid, pick the first valid level searching from rr_ptr upward, modulo LEVELS.
  - Register it in grant, clear burst_cnt, go to GRANT next cycle.
  - This costs one arbitration cycle per grant, and that bubble is accepted.
- State GRANT:
  - load = !out_valid || out_ready.
  - in_ready[grant] = load; all other in_ready bits are 0.
  - Accept: in_valid[grant] && in_ready[grant]. On accept, the output register takes in_pixels[grant], out_level=grant and out_valid=1 on the next edge. Latency is 1 cycle from accept to out_valid.
- Release (GRANT→IDLE): rr_ptr becomes (grant+1) mod LEVELS on either of these events:
  - an accept with burst_cnt==BURST_LEN-1;
  - in_valid[grant]==0 in any GRANT cycle. The pyramid downsamplers drop valid on skipped pixels, so this is a normal release path.
- When neither release condition holds, an accept increments burst_cnt and the state stays GRANT.
- BURST_LEN==1: every accept releases.
- Output register:
  - out_valid clears when out_ready && !accept.
  - A simultaneous drain and accept is a back-to-back transfer with no bubble.
  - out_pixel and out_level hold while out_valid && !out_ready.
- No beat is ever dropped or duplicated. Per-level ordering is preserved. in_ready never asserts in IDLE.
- rr_ptr wraps from LEVELS-1 to 0. The IDLE search wraps the same way, so a lone requester at index < rr_ptr is still found.
- Fairness: a continuously valid level waits at most (LEVELS-1)*(BURST_LEN+1) cycles for a grant, assuming out_ready held high.
- en deasserted mid-burst: the burst finishes normally and no new grant follows. Re-asserting en resumes arbitration from rr_ptr.
- Reset mid-burst: all state clears immediately. A pixel held in the output register is discarded, and downstream must treat reset as a frame abort.
- LEVELS not a power of two: the grant and rr_ptr arithmetic wraps explicitly at LEVELS, never via natural overflow.

Decomposition:
- Shared package pyramid_pkg holds:
  - state encoding localparams ST_IDLE, ST_GRANT;
  - the LEVEL_W derivation;
  - the next_ptr modulo-LEVELS helper function.
  The pyramid and HOG blocks reuse the package for the level tag width.
- One sub-module: rr_priority_picker. It is combinational; inputs are req[LEVELS] and ptr; outputs are found and idx. It does the rotate/priority-encode/unrotate, so it can be unit-tested on its own.

Test Plan (LEVELS=4, BURST_LEN=4, DATA_WIDTH=8 unless noted):
- Reset: assert rst mid-burst with out_valid=1 → all outputs 0 asynchronously; after release, first grant goes to level 0 if valid.
- Single level: level 2 always valid with pixels 0x10,0x11,…, out_ready=1 → outputs in order, tag 2, bursts of 4 beats separated by exactly one bubble cycle.
- All four levels continuously valid, out_ready=1 → tag sequence 0000 1111 2222 3333 0000; each level's pixel order intact.
- Backpressure: out_ready=0 for 5 cycles mid-burst → out_pixel and out_level stable, in_ready low, no beat lost; resume gives a contiguous sequence.
- Valid drop: level 1 valid for 2 beats then low, level 3 valid → release after 2 beats; next grant goes to level 3, not level 1.
- Wrap and en: rr_ptr=3 with only level 0 valid → level 0 granted. Deassert en mid-burst → burst completes to 4 beats, then no grant until en=1.

Source files
------------

// File: rtl/pyramid_pkg.sv
// Shared definitions for the gaussian pyramid / HOG path: FSM encoding,
// level tag width derivation and modulo-LEVELS pointer stepping.
package pyramid_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  function automatic int level_w(input int levels);
    return (levels > 1) ? $clog2(levels) : 1;
  endfunction

  // Explicit wrap so non-power-of-two level counts never rely on overflow.
  function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned levels);
    return (ptr >= levels - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: first set bit of req at or above ptr, wrapping at LEVELS.
// Pure combinational rotate / priority-encode / unrotate.
module rr_priority_picker
  import pyramid_pkg::*;
#(
  parameter int  LEVELS  = 15,
  localparam int LEVEL_W = level_w(LEVELS)
) (
  input  logic [LEVELS-1:0]  req,
  input  logic [LEVEL_W-1:0] ptr,
  output logic               found,
  output logic [LEVEL_W-1:0] idx
);

  localparam int SW = LEVEL_W + 1;

  logic [LEVELS-1:0]  rot;
  logic [LEVEL_W-1:0] off;
  logic [SW-1:0]      usum;

  // rot[gi] is the request gi positions above ptr, modulo LEVELS.
  for (genvar gi = 0; gi < LEVELS; gi++) begin : g_rot
    logic [SW-1:0]      sum;
    logic [LEVEL_W-1:0] src;
    assign sum     = {1'b0, ptr} + SW'(gi);
    assign src     = LEVEL_W'((sum >= SW'(LEVELS)) ? sum - SW'(LEVELS) : sum);
    assign rot[gi] = req[src];
  end

  always_comb begin
    found = 1'b0;
    off   = '0;
    for (int k = LEVELS - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        off   = LEVEL_W'(k);
      end
    end
  end

  always_comb begin
    usum = {1'b0, ptr} + {1'b0, off};
    idx  = LEVEL_W'((usum >= SW'(LEVELS)) ? usum - SW'(LEVELS) : usum);
  end

endmodule

// File: rtl/pyramid_output_arbiter.sv
// Merges the per-level pyramid pixel streams into one level-tagged stream,
// granting levels round-robin in bursts of up to BURST_LEN beats.
module pyramid_output_arbiter
  import pyramid_pkg::*;
#(
  parameter int  DATA_WIDTH = 8,
  parameter int  LEVELS     = 15,
  parameter int  BURST_LEN  = 8,
  localparam int LEVEL_W    = level_w(LEVELS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [LEVELS-1:0]            in_valid,
  input  logic [DATA_WIDTH*LEVELS-1:0] in_pixels,
  output logic [LEVELS-1:0]            in_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_pixel,
  output logic [LEVEL_W-1:0]           out_level,
  output logic                         busy
);

  localparam int              BC_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(BURST_LEN - 1);

  state_t                  state;
  logic [LEVEL_W-1:0]      rr_ptr;
  logic [LEVEL_W-1:0]      grant;
  logic [BC_W-1:0]         burst_cnt;

  logic                    pick_found;
  logic [LEVEL_W-1:0]      pick_idx;
  logic                    load;
  logic                    grant_valid;
  logic                    accept;
  logic [DATA_WIDTH-1:0]   grant_pixel;

  rr_priority_picker #(
    .LEVELS (LEVELS)
  ) u_picker (
    .req   (in_valid),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign load        = !out_valid || out_ready;
  assign grant_valid = in_valid[grant];
  assign grant_pixel = in_pixels[grant*DATA_WIDTH +: DATA_WIDTH];
  assign accept      = (state == ST_GRANT) && grant_valid && load;
  assign busy        = (state == ST_GRANT) || out_valid;

  always_comb begin
    in_ready = '0;
    if (state == ST_GRANT) in_ready[grant] = load;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      grant     <= '0;
      burst_cnt <= '0;
      out_valid <= 1'b0;
      out_pixel <= '0;
      out_level <= '0;
    end else begin
      // Output register: a drain and a fresh accept in one cycle is back-to-back.
      if (accept) begin
        out_valid <= 1'b1;
        out_pixel <= grant_pixel;
        out_level <= grant;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (en && pick_found) begin
            grant     <= pick_idx;
            burst_cnt <= '0;
            state     <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          // A dropped valid is a normal release: downsamplers skip pixels.
          if (!grant_valid || (accept && burst_cnt == BC_LAST)) begin
            rr_ptr <= LEVEL_W'(next_ptr(32'(grant), 32'(LEVELS)));
            state  <= ST_IDLE;
          end else if (accept) begin
            burst_cnt <= burst_cnt + BC_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pyramid_output_arbiter.sv
// Randomized bench for pyramid_output_arbiter with a transaction-level
// arbitration model feeding a scoreboard drained by an output monitor.
module tb_pyramid_output_arbiter;

  localparam int L  = 4;
  localparam int B  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b0;
  logic [L-1:0]  in_valid  = '0;
  logic [DW*L-1:0] in_pixels = '0;
  logic [L-1:0]  in_ready;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_pixel;
  logic [1:0]    out_level;
  logic          busy;

  pyramid_output_arbiter #(
    .DATA_WIDTH (DW),
    .LEVELS     (L),
    .BURST_LEN  (B)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (in_valid),
    .in_pixels (in_pixels),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pixel (out_pixel),
    .out_level (out_level),
    .busy      (busy)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    int lvl;
    int pix;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   seq[L];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic int pix_of(input int l, input int s);
    return (l * 64 + (s % 64)) & 255;
  endfunction

  // Reference model: which level holds the grant, beats taken in the burst,
  // round-robin pointer and whether the output slot is occupied.
  bit m_gr;
  int m_lvl, m_cnt, m_ptr;
  bit m_ov;
  bit m_load, m_acc;

  always @(negedge clk) begin
    if (rst) begin
      m_gr = 0; m_lvl = 0; m_cnt = 0; m_ptr = 0; m_ov = 0;
      sb.delete();
    end else begin
      m_load = !m_ov || out_ready;
      chk("in_ready", 32'(in_ready), (m_gr && m_load) ? 32'(1 << m_lvl) : 32'd0);
      chk("out_valid", 32'(out_valid), 32'(m_ov));
      chk("busy", 32'(busy), 32'(m_gr || m_ov));
      m_acc = m_gr && in_valid[m_lvl] && m_load;
      if (m_acc) begin
        sb.push_back('{m_lvl, pix_of(m_lvl, seq[m_lvl])});
        seq[m_lvl]++;
        m_ov = 1;
      end else if (out_ready) begin
        m_ov = 0;
      end
      if (m_gr) begin
        if (!in_valid[m_lvl] || (m_acc && m_cnt == B - 1)) begin
          m_gr  = 0;
          m_ptr = (m_lvl + 1) % L;
        end else if (m_acc) begin
          m_cnt++;
        end
      end else if (en && in_valid != 0) begin
        for (int k = L - 1; k >= 0; k--)
          if (in_valid[(m_ptr + k) % L]) m_lvl = (m_ptr + k) % L;
        m_gr  = 1;
        m_cnt = 0;
      end
    end
  end

  // Monitor: every transfer on the merged port must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_beat", 32'(out_pixel), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("out_level", 32'(out_level), 32'(e.lvl));
        chk("out_pixel", 32'(out_pixel), 32'(e.pix));
      end
    end
  end

  task automatic drive_pixels();
    for (int l = 0; l < L; l++) in_pixels[l*DW +: DW] = DW'(pix_of(l, seq[l]));
  endtask

  // mode 0: level 2 only; 1: all levels; 2: all + backpressure;
  // 3: random valids/ready with en gaps; 4: levels 0 and 3 sporadic; 5: idle drain
  task automatic run_phase(input int mode, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1;
      en = 1'b1;
      out_ready = 1'b1;
      case (mode)
        0: in_valid = 4'b0100;
        1: in_valid = 4'b1111;
        2: begin
          in_valid  = 4'b1111;
          out_ready = ((c % 40) >= 30) ? 1'b0 : ($urandom_range(9) < 7);
        end
        3: begin
          for (int l = 0; l < L; l++) in_valid[l] = ($urandom_range(9) < 6);
          out_ready = ($urandom_range(9) < 7);
          en = ((c / 25) % 4) != 3;
        end
        4: begin
          in_valid  = {($urandom_range(3) != 0), 2'b00, ($urandom_range(3) == 0)};
          out_ready = ($urandom_range(9) < 8);
        end
        default: in_valid = '0;
      endcase
      drive_pixels();
    end
  endtask

  initial begin
    int w;
    for (int l = 0; l < L; l++) seq[l] = 0;
    drive_pixels();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    en  = 1'b1;

    run_phase(0, 60);
    run_phase(1, 80);
    run_phase(2, 300);
    run_phase(3, 600);
    run_phase(4, 300);
    run_phase(1, 23);

    // Asynchronous reset while a beat sits in the output register.
    w = 0;
    while (!out_valid && w < 20) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (w >= 20) chk("rst_wait_out_valid", 32'd0, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_pixel", 32'(out_pixel), 32'd0);
    chk("arst_out_level", 32'(out_level), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_phase(1, 40);
    run_phase(3, 300);
    run_phase(5, 20);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
